// File: rtl/dp_ram_pkg.sv
// Shared types and default widths for the dual-port RAM march BIST.
package dp_ram_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 8;
    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned FAIL_CNT_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        M0_WR,
        M1_RW,
        M2_RW,
        M3_RD,
        DRAIN,
        DONE
    } bist_state_e;

endpackage

// File: rtl/dp_ram_bist_cmp.sv
// Registered read-data compare with first-failure capture and a saturating mismatch counter.
module dp_ram_bist_cmp
    import dp_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      i_clear,
    input  logic                      i_rd_en,
    input  logic [ADDR_WIDTH-1:0]     i_rd_addr,
    input  logic [DATA_WIDTH-1:0]     i_expected,
    input  logic [DATA_WIDTH-1:0]     i_rd_data,
    output logic [FAIL_CNT_WIDTH-1:0] o_fail_count,
    output logic [ADDR_WIDTH-1:0]     o_fail_addr,
    output logic [DATA_WIDTH-1:0]     o_fail_expected,
    output logic [DATA_WIDTH-1:0]     o_fail_data
);

    logic                      r_vld;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [DATA_WIDTH-1:0]     r_exp;
    logic [FAIL_CNT_WIDTH-1:0] r_fail_count;
    logic [ADDR_WIDTH-1:0]     r_fail_addr;
    logic [DATA_WIDTH-1:0]     r_fail_expected;
    logic [DATA_WIDTH-1:0]     r_fail_data;
    logic                      w_mismatch;

    assign w_mismatch = r_vld && (i_rd_data != r_exp);

    // A zero count means no failure has been captured yet this run; the count never wraps back to zero.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_vld           <= 1'b0;
            r_addr          <= '0;
            r_exp           <= '0;
            r_fail_count    <= '0;
            r_fail_addr     <= '0;
            r_fail_expected <= '0;
            r_fail_data     <= '0;
        end else if (i_clear) begin
            r_vld           <= 1'b0;
            r_fail_count    <= '0;
            r_fail_addr     <= '0;
            r_fail_expected <= '0;
            r_fail_data     <= '0;
        end else begin
            r_vld <= i_rd_en;
            if (i_rd_en) begin
                r_addr <= i_rd_addr;
                r_exp  <= i_expected;
            end
            if (w_mismatch) begin
                if (r_fail_count != '1) begin
                    r_fail_count <= r_fail_count + FAIL_CNT_WIDTH'(1);
                end
                if (r_fail_count == '0) begin
                    r_fail_addr     <= r_addr;
                    r_fail_expected <= r_exp;
                    r_fail_data     <= i_rd_data;
                end
            end
        end
    end

    assign o_fail_count    = r_fail_count;
    assign o_fail_addr     = r_fail_addr;
    assign o_fail_expected = r_fail_expected;
    assign o_fail_data     = r_fail_data;

endmodule

// File: rtl/dp_ram_bist_ctrl.sv
// March BIST controller for a dual-port RAM: four march elements, then a drain cycle and a done pulse.
module dp_ram_bist_ctrl
    import dp_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      start,
    input  logic [DATA_WIDTH-1:0]     pattern,
    output logic                      mem_wr_en,
    output logic [ADDR_WIDTH-1:0]     mem_wr_addr,
    output logic [DATA_WIDTH-1:0]     mem_wr_data,
    output logic                      mem_rd_en,
    output logic [ADDR_WIDTH-1:0]     mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]     mem_rd_data,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [FAIL_CNT_WIDTH-1:0] fail_count,
    output logic [ADDR_WIDTH-1:0]     fail_addr,
    output logic [DATA_WIDTH-1:0]     fail_expected,
    output logic [DATA_WIDTH-1:0]     fail_data
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    bist_state_e           r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic [DATA_WIDTH-1:0] r_pat, w_pat_nxt;
    logic                  r_wr_en, w_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr, w_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data, w_wr_data;
    logic                  r_rd_en, w_rd_en;
    logic [ADDR_WIDTH-1:0] r_rd_addr, w_rd_addr;
    logic [DATA_WIDTH-1:0] r_expected, w_expected;
    logic                  r_busy, w_busy;
    logic                  r_done, w_done;
    logic                  r_pass, w_pass;
    logic                  w_clear;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_pat      <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_expected <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_pat      <= w_pat_nxt;
            r_wr_en    <= w_wr_en;
            r_wr_addr  <= w_wr_addr;
            r_wr_data  <= w_wr_data;
            r_rd_en    <= w_rd_en;
            r_rd_addr  <= w_rd_addr;
            r_expected <= w_expected;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_pass     <= w_pass;
        end
    end

    // Next state/address, then the RAM command for the next cycle decoded from them so outputs stay registered.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_pat_nxt   = r_pat;
        w_pass      = r_pass;
        w_clear     = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_addr   = r_wr_addr;
        w_wr_data   = r_wr_data;
        w_rd_en     = 1'b0;
        w_rd_addr   = r_rd_addr;
        w_expected  = r_expected;

        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = M0_WR;
                    w_addr_nxt  = '0;
                    w_pat_nxt   = pattern;
                    w_pass      = 1'b0;
                    w_clear     = 1'b1;
                end
            end
            M0_WR: begin
                if (r_addr == ADDR_MAX) begin
                    w_state_nxt = M1_RW;
                    w_addr_nxt  = '0;
                end else begin
                    w_addr_nxt = r_addr + ADDR_WIDTH'(1);
                end
            end
            M1_RW: begin
                if (r_addr == ADDR_MAX) begin
                    w_state_nxt = M2_RW;
                    w_addr_nxt  = ADDR_MAX;
                end else begin
                    w_addr_nxt = r_addr + ADDR_WIDTH'(1);
                end
            end
            M2_RW: begin
                if (r_addr == '0) begin
                    w_state_nxt = M3_RD;
                    w_addr_nxt  = '0;
                end else begin
                    w_addr_nxt = r_addr - ADDR_WIDTH'(1);
                end
            end
            M3_RD: begin
                if (r_addr == ADDR_MAX) begin
                    w_state_nxt = DRAIN;
                end else begin
                    w_addr_nxt = r_addr + ADDR_WIDTH'(1);
                end
            end
            DRAIN: w_state_nxt = DONE;
            DONE: begin
                w_state_nxt = IDLE;
                w_pass      = (fail_count == '0);
            end
            default: w_state_nxt = IDLE;
        endcase

        unique case (w_state_nxt)
            M0_WR: begin
                w_wr_en   = 1'b1;
                w_wr_addr = w_addr_nxt;
                w_wr_data = w_pat_nxt;
            end
            M1_RW, M2_RW: begin
                w_wr_en    = 1'b1;
                w_wr_addr  = w_addr_nxt;
                w_wr_data  = (w_state_nxt == M1_RW) ? ~w_pat_nxt : w_pat_nxt;
                w_rd_en    = 1'b1;
                w_rd_addr  = w_addr_nxt;
                w_expected = (w_state_nxt == M1_RW) ? w_pat_nxt : ~w_pat_nxt;
            end
            M3_RD: begin
                w_rd_en    = 1'b1;
                w_rd_addr  = w_addr_nxt;
                w_expected = w_pat_nxt;
            end
            default: ;
        endcase

        w_busy = w_state_nxt inside {M0_WR, M1_RW, M2_RW, M3_RD, DRAIN};
        w_done = (w_state_nxt == DONE);
    end

    dp_ram_bist_cmp #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cmp (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .i_clear         (w_clear),
        .i_rd_en         (r_rd_en),
        .i_rd_addr       (r_rd_addr),
        .i_expected      (r_expected),
        .i_rd_data       (mem_rd_data),
        .o_fail_count    (fail_count),
        .o_fail_addr     (fail_addr),
        .o_fail_expected (fail_expected),
        .o_fail_data     (fail_data)
    );

    assign mem_wr_en   = r_wr_en;
    assign mem_wr_addr = r_wr_addr;
    assign mem_wr_data = r_wr_data;
    assign mem_rd_en   = r_rd_en;
    assign mem_rd_addr = r_rd_addr;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;

endmodule

// File: tb/tb_dp_ram_bist_ctrl.sv
// Bench for dp_ram_bist_ctrl: dual-port RAM model with injectable faults and a march-algorithm reference model.
`timescale 1ns/1ps
module tb_dp_ram_bist_ctrl;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 32;
    localparam int          N  = 16;
    localparam int FK_NONE = 0, FK_STUCK0 = 1, FK_RD_ZERO = 2, FK_RD_INV = 3;

    typedef logic [41:0] acc_t;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic          start;
    logic [DW-1:0] pattern;
    logic          mem_wr_en, mem_rd_en;
    logic [AW-1:0] mem_wr_addr, mem_rd_addr;
    logic [DW-1:0] mem_wr_data, mem_rd_data;
    logic          busy, done, pass;
    logic [15:0]   fail_count;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_expected, fail_data;

    dp_ram_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .start         (start),
        .pattern       (pattern),
        .mem_wr_en     (mem_wr_en),
        .mem_wr_addr   (mem_wr_addr),
        .mem_wr_data   (mem_wr_data),
        .mem_rd_en     (mem_rd_en),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_data   (mem_rd_data),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .fail_count    (fail_count),
        .fail_addr     (fail_addr),
        .fail_expected (fail_expected),
        .fail_data     (fail_data)
    );

    always #5 clk_in = ~clk_in;

    int fault_kind = FK_NONE;
    int fault_addr = 0;
    int fault_bit  = 0;

    function automatic logic [DW-1:0] f_wr(input int a, input logic [DW-1:0] d);
        logic [DW-1:0] m;
        m = d;
        if (fault_kind == FK_STUCK0 && a == fault_addr) m[fault_bit] = 1'b0;
        return m;
    endfunction

    function automatic logic [DW-1:0] f_rd(input logic [DW-1:0] s);
        if (fault_kind == FK_RD_ZERO) return '0;
        if (fault_kind == FK_RD_INV)  return ~s;
        return s;
    endfunction

    // Synchronous dual-port RAM; a same-address read returns the old word.
    logic [DW-1:0] ram [N];
    always @(posedge clk_in) begin
        if (mem_rd_en) mem_rd_data <= f_rd(ram[mem_rd_addr]);
        if (mem_wr_en) ram[mem_wr_addr] <= f_wr(int'(mem_wr_addr), mem_wr_data);
    end

    int n_checks = 0;
    int n_fails  = 0;
    int done_seen = 0;
    always @(negedge clk_in) if (done === 1'b1) done_seen++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic acc_t mk_acc(input logic rd, input logic [AW-1:0] ra,
                                    input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        return {rd, rd ? ra : 4'h0, wr, wr ? wa : 4'h0, wr ? wd : 32'h0};
    endfunction

    // Reference march run: expected per-cycle RAM commands and the resulting verdict.
    acc_t          exp_q[$];
    int            m_cnt;
    logic [AW-1:0] m_faddr;
    logic [DW-1:0] m_fexp, m_fdata;
    logic [DW-1:0] m_mem [N];

    task automatic model_cmp(input int a, input logic [DW-1:0] e, input logic [DW-1:0] d);
        if (d != e) begin
            if (m_cnt == 0) begin
                m_faddr = AW'(a);
                m_fexp  = e;
                m_fdata = d;
            end
            m_cnt++;
        end
    endtask

    task automatic model_run(input logic [DW-1:0] p);
        exp_q.delete();
        m_cnt = 0; m_faddr = '0; m_fexp = '0; m_fdata = '0;
        for (int a = 0; a < N; a++) begin
            exp_q.push_back(mk_acc(1'b0, 4'h0, 1'b1, AW'(a), p));
            m_mem[a] = f_wr(a, p);
        end
        for (int a = 0; a < N; a++) begin
            model_cmp(a, p, f_rd(m_mem[a]));
            exp_q.push_back(mk_acc(1'b1, AW'(a), 1'b1, AW'(a), ~p));
            m_mem[a] = f_wr(a, ~p);
        end
        for (int a = N - 1; a >= 0; a--) begin
            model_cmp(a, ~p, f_rd(m_mem[a]));
            exp_q.push_back(mk_acc(1'b1, AW'(a), 1'b1, AW'(a), p));
            m_mem[a] = f_wr(a, p);
        end
        for (int a = 0; a < N; a++) begin
            model_cmp(a, p, f_rd(m_mem[a]));
            exp_q.push_back(mk_acc(1'b1, AW'(a), 1'b0, 4'h0, 32'h0));
        end
        exp_q.push_back(mk_acc(1'b0, 4'h0, 1'b0, 4'h0, 32'h0));
    endtask

    function automatic logic any_out();
        return |{mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr, busy, done, pass,
                 fail_count, fail_addr, fail_expected, fail_data};
    endfunction

    task automatic run_test(input string name, input logic [DW-1:0] p, input int kind,
                            input int faddr, input int fbit, input int start_at, input int rst_at);
        int  cyc;
        int  d0;
        bit  aborted;
        fault_kind = kind; fault_addr = faddr; fault_bit = fbit;
        model_run(p);
        d0 = done_seen;
        aborted = 1'b0;
        @(negedge clk_in);
        start = 1'b1; pattern = p;
        @(negedge clk_in);
        start = 1'b0; pattern = $urandom;
        cyc = 0;
        while (busy === 1'b1 && cyc < 4 * N + 10) begin
            if (cyc < exp_q.size())
                chk({name, "_acc"}, 64'(mk_acc(mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data)),
                    64'(exp_q[cyc]));
            if (cyc == rst_at) begin
                rst_n_in = 1'b0;
                #1;
                chk({name, "_rst_outs"}, 64'(any_out()), 64'd0);
                aborted = 1'b1;
                break;
            end
            start = (cyc == start_at);
            if (start) pattern = $urandom;
            @(negedge clk_in);
            cyc++;
        end
        start = 1'b0;
        if (aborted) begin
            repeat (2) @(negedge clk_in);
            rst_n_in = 1'b1;
            repeat (4 * N + 10) @(negedge clk_in);
            chk({name, "_no_done"}, 64'(done_seen - d0), 64'd0);
            chk({name, "_idle_busy"}, 64'(busy), 64'd0);
            return;
        end
        chk({name, "_busy_cycles"}, 64'(cyc), 64'(4 * N + 1));
        chk({name, "_done_hi"}, 64'(done), 64'd1);
        @(negedge clk_in);
        chk({name, "_done_lo"}, 64'(done), 64'd0);
        chk({name, "_done_cnt"}, 64'(done_seen - d0), 64'd1);
        chk({name, "_pass"}, 64'(pass), 64'(m_cnt == 0));
        chk({name, "_fail_count"}, 64'(fail_count), 64'(m_cnt > 65535 ? 65535 : m_cnt));
        chk({name, "_fail_addr"}, 64'(fail_addr), 64'(m_faddr));
        chk({name, "_fail_exp"}, 64'(fail_expected), 64'(m_fexp));
        chk({name, "_fail_data"}, 64'(fail_data), 64'(m_fdata));
        for (int a = 0; a < N; a++) chk({name, "_ram"}, 64'(ram[a]), 64'(m_mem[a]));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_in = 1'b0; start = 1'b0; pattern = '0;
        repeat (3) @(negedge clk_in);
        chk("reset_outs", 64'(any_out()), 64'd0);
        rst_n_in = 1'b1;
        @(negedge clk_in);

        run_test("fault_free", 32'hA5A5A5A5, FK_NONE, 0, 0, -1, -1);
        chk("fault_free_pass_const", 64'(pass), 64'd1);
        chk("fault_free_cnt_const", 64'(fail_count), 64'd0);
        for (int a = 0; a < N; a++) chk("fault_free_ram_const", 64'(ram[a]), 64'hA5A5A5A5);

        run_test("stuck0", 32'hA5A5A5A5, FK_STUCK0, 5, 0, -1, -1);
        chk("stuck0_cnt_const", 64'(fail_count), 64'd2);
        chk("stuck0_addr_const", 64'(fail_addr), 64'd5);
        chk("stuck0_exp_const", 64'(fail_expected), 64'hA5A5A5A5);
        chk("stuck0_data_const", 64'(fail_data), 64'hA5A5A5A4);
        chk("stuck0_pass_const", 64'(pass), 64'd0);

        run_test("mid_start", $urandom, FK_NONE, 0, 0, 20, -1);
        run_test("mid_reset", $urandom, FK_NONE, 0, 0, -1, 30);
        run_test("after_reset", $urandom, FK_NONE, 0, 0, -1, -1);
        chk("after_reset_pass_const", 64'(pass), 64'd1);

        run_test("rd_zero", 32'hFFFFFFFF, FK_RD_ZERO, 0, 0, -1, -1);
        run_test("rd_inv", 32'hFFFFFFFF, FK_RD_INV, 0, 0, -1, -1);
        chk("rd_inv_cnt_const", 64'(fail_count), 64'd48);
        chk("rd_inv_addr_const", 64'(fail_addr), 64'd0);

        for (int i = 0; i < 6; i++)
            run_test("random", $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, N - 1)),
                     int'($urandom_range(0, DW - 1)), int'($urandom_range(0, 4 * N)), -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
